// File: rtl/reorder_buffer_pkg.sv
// Shared sizing constants and payload types for the reorder buffer and its interface.
package reorder_buffer_pkg;

    localparam int unsigned ROB_W    = 4;
    localparam int unsigned ROB_SIZE = 1 << ROB_W;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_W    = 5;

    // Tag meaning "no producer": one bit wider than any real entry index.
    localparam logic [ROB_W:0] ROB_NONE = {1'b1, {ROB_W{1'b0}}};

    // Result captured from the CDB for one entry.
    typedef struct packed {
        logic [XLEN-1:0] val;
        logic            mispredict;
        logic [XLEN-1:0] target;
    } wb_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue/rename, CDB, operand query, commit and flush signals of the reorder buffer.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic             issue_valid;
    logic [REG_W-1:0] issue_rd;
    logic             issue_is_branch;
    logic             issue_ready;
    logic [ROB_W-1:0] issue_ROB_pos;

    logic             update_valid;
    logic [ROB_W-1:0] update_ROB_pos;
    logic [REG_W-1:0] update_rd;

    logic             cdb_valid;
    logic [ROB_W-1:0] cdb_ROB_pos;
    logic [XLEN-1:0]  cdb_val;
    logic             cdb_mispredict;
    logic [XLEN-1:0]  cdb_target;

    logic [ROB_W-1:0] query_pos1;
    logic [ROB_W-1:0] query_pos2;
    logic             query_ready1;
    logic             query_ready2;
    logic [XLEN-1:0]  query_val1;
    logic [XLEN-1:0]  query_val2;

    logic             commit_valid;
    logic [ROB_W-1:0] commit_ROB_pos;
    logic [REG_W-1:0] commit_rd;
    logic [XLEN-1:0]  commit_val;

    logic             flush;
    logic [XLEN-1:0]  flush_pc;

    modport master (
        output issue_valid, issue_rd, issue_is_branch,
        output cdb_valid, cdb_ROB_pos, cdb_val, cdb_mispredict, cdb_target,
        output query_pos1, query_pos2,
        input  issue_ready, issue_ROB_pos,
        input  update_valid, update_ROB_pos, update_rd,
        input  query_ready1, query_ready2, query_val1, query_val2,
        input  commit_valid, commit_ROB_pos, commit_rd, commit_val,
        input  flush, flush_pc
    );

    modport slave (
        input  issue_valid, issue_rd, issue_is_branch,
        input  cdb_valid, cdb_ROB_pos, cdb_val, cdb_mispredict, cdb_target,
        input  query_pos1, query_pos2,
        output issue_ready, issue_ROB_pos,
        output update_valid, update_ROB_pos, update_rd,
        output query_ready1, query_ready2, query_val1, query_val2,
        output commit_valid, commit_ROB_pos, commit_rd, commit_val,
        output flush, flush_pc
    );

endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates on issue, captures CDB results, retires in
// program order and flushes the machine when a mispredicted branch retires.
module reorder_buffer #(
    parameter int unsigned ROB_W = reorder_buffer_pkg::ROB_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    reorder_buffer_if.slave  bus
);
    import reorder_buffer_pkg::*;

    localparam int unsigned DEPTH = 1 << ROB_W;
    localparam int unsigned CNT_W = ROB_W + 1;

    logic [ROB_W-1:0] head;
    logic [ROB_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] br_q;
    logic [REG_W-1:0] rd_q [DEPTH];
    wb_t              wb_q [DEPTH];

    logic full;
    logic empty;
    logic accept;
    logic issue_wr;
    logic cdb_wr;
    logic commit_fire;
    logic flush_fire;
    logic hit1;
    logic hit2;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign accept = bus.issue_valid && !full && rdy;

    assign cdb_wr      = rdy && bus.cdb_valid && busy[bus.cdb_ROB_pos];
    assign commit_fire = rdy && !empty && busy[head] && ready[head];
    assign flush_fire  = commit_fire && br_q[head] && wb_q[head].mispredict;
    // A flush retiring this cycle wins over a same-cycle allocation.
    assign issue_wr    = accept && !flush_fire;

    assign bus.issue_ready    = !full;
    assign bus.issue_ROB_pos  = tail;
    assign bus.update_valid   = accept;
    assign bus.update_ROB_pos = tail;
    assign bus.update_rd      = bus.issue_rd;

    // Operand lookup with same-cycle CDB bypass.
    assign hit1 = cdb_wr && (bus.cdb_ROB_pos == bus.query_pos1);
    assign hit2 = cdb_wr && (bus.cdb_ROB_pos == bus.query_pos2);
    assign bus.query_ready1 = hit1 || (busy[bus.query_pos1] && ready[bus.query_pos1]);
    assign bus.query_ready2 = hit2 || (busy[bus.query_pos2] && ready[bus.query_pos2]);
    assign bus.query_val1   = hit1 ? bus.cdb_val : wb_q[bus.query_pos1].val;
    assign bus.query_val2   = hit2 ? bus.cdb_val : wb_q[bus.query_pos2].val;

    // Queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (flush_fire) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (issue_wr)    tail <= tail + ROB_W'(1);
                if (commit_fire) head <= head + ROB_W'(1);
                count <= count + CNT_W'(issue_wr) - CNT_W'(commit_fire);
            end
        end
    end

    // Per-entry status bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= '0;
            ready <= '0;
        end else if (rdy) begin
            if (issue_wr) begin
                busy[tail]  <= 1'b1;
                ready[tail] <= 1'b0;
            end
            if (cdb_wr)      ready[bus.cdb_ROB_pos] <= 1'b1;
            if (commit_fire) busy[head] <= 1'b0;
            if (flush_fire)  busy <= '0;
        end
    end

    // Entry payloads; only meaningful while the matching busy/ready bit is set.
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (issue_wr) begin
                rd_q[tail] <= bus.issue_rd;
                br_q[tail] <= bus.issue_is_branch;
            end
            if (cdb_wr) begin
                wb_q[bus.cdb_ROB_pos] <= '{val:        bus.cdb_val,
                                           mispredict: bus.cdb_mispredict,
                                           target:     bus.cdb_target};
            end
        end
    end

    // Registered retirement and redirect pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.commit_valid   <= 1'b0;
            bus.commit_ROB_pos <= '0;
            bus.commit_rd      <= '0;
            bus.commit_val     <= '0;
            bus.flush          <= 1'b0;
            bus.flush_pc       <= '0;
        end else if (rdy) begin
            bus.commit_valid <= commit_fire;
            bus.flush        <= flush_fire;
            if (commit_fire) begin
                bus.commit_ROB_pos <= head;
                bus.commit_rd      <= rd_q[head];
                bus.commit_val     <= wb_q[head].val;
            end
            if (flush_fire) bus.flush_pc <= wb_q[head].target;
        end else begin
            bus.commit_valid <= 1'b0;
            bus.flush        <= 1'b0;
        end
    end

endmodule
